// File: rtl/sfa_pkg.sv
// Shared types and helpers for the sample fetch arbiter.
package sfa_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } sfa_state_t;

    localparam logic [7:0] DL_INDEX_DEFAULT = 8'd2;

    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned num_ch);
        return (idx + 1 >= num_ch) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/sfa_rr_pick.sv
// Round-robin picker: first asserted request at or after ptr, wrapping.
module sfa_rr_pick #(
    parameter int NUM_CH = 4,
    parameter int IDX_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic [NUM_CH-1:0] gnt,
    output logic [IDX_W-1:0]  idx,
    output logic              found
);

    always_comb begin
        logic [IDX_W-1:0] j;
        j     = '0;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            j = IDX_W'((int'(ptr) + k) % NUM_CH);
            if (!found && req[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = j;
            end
        end
    end

endmodule

// File: rtl/sample_fetch_arbiter.sv
// Shares one SDRAM word port between the sample download stream (byte packed
// into words, absolute priority) and round-robin playback read channels.
//
// state | meaning
// IDLE  | choose pending download write, else round-robin channel read
// ISSUE | first cycle of mem_req, command already latched
// WAIT  | mem_req and command held until mem_ack
module sample_fetch_arbiter
    import sfa_pkg::*;
#(
    parameter int         NUM_CH   = 4,
    parameter int         ADDR_W   = 24,
    parameter logic [7:0] DL_INDEX = DL_INDEX_DEFAULT
) (
    input  logic                     clk_sys,
    input  logic                     reset_n,
    input  logic                     dl_download,
    input  logic [7:0]               dl_index,
    input  logic                     dl_wr,
    input  logic [24:0]              dl_addr,
    input  logic [7:0]               dl_data,
    output logic                     dl_overrun,
    input  logic [NUM_CH-1:0]        ch_req,
    input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
    output logic [NUM_CH-1:0]        ch_gnt,
    output logic [NUM_CH-1:0]        ch_valid,
    output logic [15:0]              rd_data,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [15:0]              mem_din,
    input  logic                     mem_ack,
    input  logic [15:0]              mem_dout
);

    localparam int IDX_W = $clog2(NUM_CH);

    sfa_state_t state_q, state_d;
    logic load_wr, load_rd;

    logic              dl_active, dl_download_q, dl_rise;
    logic              byte_pending, wr_pending, wr_busy;
    logic [7:0]        low_byte;
    logic [ADDR_W-1:0] low_addr, wr_addr, sel_addr;
    logic [15:0]       wr_word;
    logic              wr_ack, rd_ack;

    logic [IDX_W-1:0]  ptr, gnt_idx, pick_idx;
    logic [NUM_CH-1:0] gnt_oh, pick_gnt;
    logic              pick_found;

    assign dl_active = dl_download && (dl_index == DL_INDEX);
    assign dl_rise   = dl_download && !dl_download_q;
    assign wr_ack    = (state_q == ST_WAIT) && mem_ack && mem_we;
    assign rd_ack    = (state_q == ST_WAIT) && mem_ack && !mem_we;
    // A slot freed by this cycle's ack can take a new word in the same cycle.
    assign wr_busy   = wr_pending && !wr_ack;
    assign mem_req   = (state_q != ST_IDLE);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            dl_download_q <= 1'b0;
            dl_overrun    <= 1'b0;
            byte_pending  <= 1'b0;
            wr_pending    <= 1'b0;
            low_byte      <= '0;
            low_addr      <= '0;
            wr_addr       <= '0;
            wr_word       <= '0;
        end else begin
            dl_download_q <= dl_download;
            if (wr_ack)
                wr_pending <= 1'b0;
            if (dl_rise)
                dl_overrun <= 1'b0;
            if (dl_active && dl_wr) begin
                if (!dl_addr[0]) begin
                    low_byte     <= dl_data;
                    low_addr     <= ADDR_W'(dl_addr[24:1]);
                    byte_pending <= 1'b1;
                end else begin
                    byte_pending <= 1'b0;
                    if (wr_busy) begin
                        dl_overrun <= 1'b1;
                    end else begin
                        wr_pending <= 1'b1;
                        wr_word    <= {dl_data, byte_pending ? low_byte : 8'h00};
                        wr_addr    <= ADDR_W'(dl_addr[24:1]);
                    end
                end
            end else if (byte_pending && !dl_download && !wr_busy) begin
                // Trailing even byte after download end; waits for a free slot.
                wr_pending   <= 1'b1;
                wr_word      <= {8'h00, low_byte};
                wr_addr      <= low_addr;
                byte_pending <= 1'b0;
            end
        end
    end

    sfa_rr_pick #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_pick (
        .req   (ch_req),
        .ptr   (ptr),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .found (pick_found)
    );

    always_comb begin
        sel_addr = '0;
        for (int k = 0; k < NUM_CH; k++)
            if (pick_idx == IDX_W'(k))
                sel_addr = ch_addr[k*ADDR_W +: ADDR_W];
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        load_wr = 1'b0;
        load_rd = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (wr_pending) begin
                    load_wr = 1'b1;
                    state_d = ST_ISSUE;
                end else if (!dl_active && !byte_pending && pick_found) begin
                    load_rd = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  if (mem_ack) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
            ch_gnt   <= '0;
            ch_valid <= '0;
            rd_data  <= '0;
            gnt_oh   <= '0;
            gnt_idx  <= '0;
            ptr      <= '0;
        end else begin
            ch_gnt   <= '0;
            ch_valid <= '0;
            if (load_wr) begin
                mem_we   <= 1'b1;
                mem_addr <= wr_addr;
                mem_din  <= wr_word;
            end else if (load_rd) begin
                mem_we   <= 1'b0;
                mem_addr <= sel_addr;
                mem_din  <= '0;
                ch_gnt   <= pick_gnt;
                gnt_oh   <= pick_gnt;
                gnt_idx  <= pick_idx;
            end
            if (rd_ack) begin
                rd_data  <= mem_dout;
                ch_valid <= gnt_oh;
                ptr      <= IDX_W'(rr_next(32'(gnt_idx), NUM_CH));
            end
        end
    end

endmodule

// File: tb/tb_sample_fetch_arbiter.sv
// Directed bench for sample_fetch_arbiter: SDRAM responder model plus a
// scoreboard monitor checking requests, grants and read returns.
module tb_sample_fetch_arbiter;

    localparam int NUM_CH = 4;
    localparam int ADDR_W = 24;

    logic                     clk_sys, reset_n;
    logic                     dl_download, dl_wr, dl_overrun;
    logic [7:0]               dl_index, dl_data;
    logic [24:0]              dl_addr;
    logic [NUM_CH-1:0]        ch_req, ch_gnt, ch_valid;
    logic [NUM_CH*ADDR_W-1:0] ch_addr;
    logic [15:0]              rd_data, mem_din, mem_dout;
    logic                     mem_req, mem_we, mem_ack;
    logic [ADDR_W-1:0]        mem_addr;

    typedef struct packed { logic we; logic [23:0] addr; logic [15:0] din; } mem_exp_t;
    typedef struct packed { logic [3:0] ch; logic [15:0] data; } val_exp_t;

    mem_exp_t exp_mem[$];
    int       exp_gnt[$];
    val_exp_t exp_val[$];

    int checks = 0, errors = 0;
    int cyc = 0, ack_cyc = -10, gnt_seen = 0, ack_lat = 2;
    bit hold_ack = 0;

    logic [23:0] addr_tab [4] = '{24'h000100, 24'h000200, 24'h000300, 24'h000400};
    logic [15:0] data_tab [4] = '{16'h1234, 16'h1334, 16'h1434, 16'h1534};

    sample_fetch_arbiter #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DL_INDEX(8'd2)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n),
        .dl_download(dl_download), .dl_index(dl_index), .dl_wr(dl_wr),
        .dl_addr(dl_addr), .dl_data(dl_data), .dl_overrun(dl_overrun),
        .ch_req(ch_req), .ch_addr(ch_addr), .ch_gnt(ch_gnt), .ch_valid(ch_valid),
        .rd_data(rd_data), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_ack(mem_ack), .mem_dout(mem_dout)
    );

    initial begin
        clk_sys = 0;
        forever #10 clk_sys = ~clk_sys;
    end

    always @(posedge clk_sys) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        errors++;
        $display("FAIL %s (bound expired or unexpected output)", name);
    endtask

    function automatic logic [15:0] mem_word(input logic [23:0] a);
        return a[15:0] + 16'h1134;
    endfunction

    // SDRAM responder: ack ack_lat cycles after the request first appears.
    initial begin
        int cnt;
        bit acked;
        cnt = 0;
        acked = 0;
        mem_ack = 0;
        mem_dout = '0;
        forever begin
            @(negedge clk_sys);
            #1;
            mem_ack = 0;
            if (!mem_req) begin
                cnt = 0;
                acked = 0;
            end else if (!acked) begin
                if (cnt >= ack_lat && !hold_ack) begin
                    mem_ack  = 1;
                    mem_dout = mem_word(mem_addr);
                    ack_cyc  = cyc;
                    acked    = 1;
                end
                cnt++;
            end
        end
    end

    // Scoreboard monitor.
    initial begin
        bit       req_prev;
        mem_exp_t m;
        val_exp_t v;
        int       g;
        req_prev = 0;
        forever begin
            @(negedge clk_sys);
            if (mem_req && !req_prev) begin
                if (exp_mem.size() == 0) flag("mem_req_unexpected");
                else begin
                    m = exp_mem.pop_front();
                    check("mem_we", 32'(mem_we), 32'(m.we));
                    check("mem_addr", 32'(mem_addr), 32'(m.addr));
                    if (m.we) check("mem_din", 32'(mem_din), 32'(m.din));
                end
            end
            req_prev = mem_req;
            if (ch_gnt != 0) begin
                gnt_seen++;
                if (exp_gnt.size() == 0) flag("ch_gnt_unexpected");
                else begin
                    g = exp_gnt.pop_front();
                    check("ch_gnt", 32'(ch_gnt), 32'(4'b0001 << g));
                end
            end
            if (ch_valid != 0) begin
                if (exp_val.size() == 0) flag("ch_valid_unexpected");
                else begin
                    v = exp_val.pop_front();
                    check("ch_valid", 32'(ch_valid), 32'(4'b0001 << v.ch));
                    check("rd_data", 32'(rd_data), 32'(v.data));
                    check("valid_after_ack", 32'(cyc), 32'(ack_cyc + 1));
                end
            end
        end
    end

    task automatic push_wr(input logic [23:0] a, input logic [15:0] d);
        exp_mem.push_back(mem_exp_t'{1'b1, a, d});
    endtask

    task automatic push_rd(input int ch);
        exp_mem.push_back(mem_exp_t'{1'b0, addr_tab[ch], 16'h0000});
        exp_gnt.push_back(ch);
        exp_val.push_back(val_exp_t'{4'(ch), data_tab[ch]});
    endtask

    task automatic dl_byte(input logic [24:0] a, input logic [7:0] d);
        @(negedge clk_sys);
        dl_wr = 1; dl_addr = a; dl_data = d;
        @(negedge clk_sys);
        dl_wr = 0;
    endtask

    task automatic wait_gnt(input int target, input string name);
        int n;
        n = 0;
        while (gnt_seen < target && n < 200) begin
            @(negedge clk_sys);
            n++;
        end
        if (gnt_seen < target) flag(name);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_mem.size() != 0 || exp_gnt.size() != 0 || exp_val.size() != 0 || mem_req)
               && n < 300) begin
            @(negedge clk_sys);
            n++;
        end
        if (exp_mem.size() != 0 || exp_gnt.size() != 0 || exp_val.size() != 0 || mem_req)
            flag(name);
        repeat (2) @(negedge clk_sys);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        reset_n = 0; dl_download = 0; dl_index = 8'd2; dl_wr = 0; dl_addr = '0; dl_data = '0;
        ch_req = '0;
        for (int i = 0; i < NUM_CH; i++) ch_addr[i*ADDR_W +: ADDR_W] = addr_tab[i];
        #25;
        check("rst_mem_req", 32'(mem_req), 0);
        check("rst_mem_we", 32'(mem_we), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_ch_gnt", 32'(ch_gnt), 0);
        check("rst_ch_valid", 32'(ch_valid), 0);
        check("rst_rd_data", 32'(rd_data), 0);
        check("rst_overrun", 32'(dl_overrun), 0);
        @(negedge clk_sys);
        reset_n = 1;
        repeat (2) @(negedge clk_sys);

        // Byte pair packs into one word.
        dl_download = 1;
        @(negedge clk_sys);
        push_wr(24'd0, 16'h2211);
        dl_byte(25'd0, 8'h11);
        dl_byte(25'd1, 8'h22);
        drain("drain_pair");
        check("pair_overrun", 32'(dl_overrun), 0);

        // Three bytes then download end flushes trailing byte.
        push_wr(24'd0, 16'hBBAA);
        push_wr(24'd1, 16'h00CC);
        dl_byte(25'd0, 8'hAA);
        dl_byte(25'd1, 8'hBB);
        dl_byte(25'd2, 8'hCC);
        dl_download = 0;
        drain("drain_flush");

        // Overrun: second word while first still pending; odd byte alone gets low 0x00.
        dl_download = 1;
        hold_ack = 1;
        push_wr(24'd2, 16'h4400);
        dl_byte(25'd5, 8'h44);
        dl_byte(25'd7, 8'h88);
        repeat (2) @(negedge clk_sys);
        check("overrun_set", 32'(dl_overrun), 1);
        hold_ack = 0;
        drain("drain_overrun");
        check("overrun_sticky", 32'(dl_overrun), 1);
        dl_download = 0;
        repeat (2) @(negedge clk_sys);
        check("overrun_after_fall", 32'(dl_overrun), 1);
        dl_download = 1;
        repeat (2) @(negedge clk_sys);
        check("overrun_cleared_rise", 32'(dl_overrun), 0);

        // New word in the same cycle the pending one is acked: accepted.
        hold_ack = 1;
        push_wr(24'd4, 16'h6655);
        dl_byte(25'd8, 8'h55);
        dl_byte(25'd9, 8'h66);
        repeat (6) @(negedge clk_sys);
        push_wr(24'd5, 16'h9900);
        @(negedge clk_sys);
        hold_ack = 0; dl_wr = 1; dl_addr = 25'd11; dl_data = 8'h99;
        @(negedge clk_sys);
        dl_wr = 0;
        drain("drain_same_cycle");
        check("same_cycle_no_overrun", 32'(dl_overrun), 0);
        dl_download = 0;
        repeat (2) @(negedge clk_sys);

        // Round robin with all channels requesting.
        base = gnt_seen;
        push_rd(0); push_rd(1); push_rd(2); push_rd(3); push_rd(0);
        ch_req = 4'b1111;
        wait_gnt(base + 5, "rr_grants");
        ch_req = '0;
        drain("drain_rr");

        // Channel blocked during download until flush write completes.
        dl_download = 1;
        ch_req = 4'b0100;
        base = gnt_seen;
        push_wr(24'd8, 16'hADDE);
        push_wr(24'd9, 16'h00EF);
        push_rd(2);
        dl_byte(25'h10, 8'hDE);
        dl_byte(25'h11, 8'hAD);
        dl_byte(25'h12, 8'hEF);
        repeat (12) @(negedge clk_sys);
        check("no_gnt_while_dl", 32'(gnt_seen), 32'(base));
        dl_download = 0;
        wait_gnt(base + 1, "gnt_after_dl");
        ch_req = '0;
        drain("drain_block");

        // Reset in WAIT: outputs drop asynchronously, pointer back to 0.
        hold_ack = 1;
        base = gnt_seen;
        exp_mem.push_back(mem_exp_t'{1'b0, addr_tab[1], 16'h0000});
        exp_gnt.push_back(1);
        ch_req = 4'b0010;
        wait_gnt(base + 1, "gnt_before_reset");
        ch_req = '0;
        repeat (3) @(negedge clk_sys);
        check("wait_mem_req", 32'(mem_req), 1);
        reset_n = 0;
        #1;
        check("async_mem_req", 32'(mem_req), 0);
        check("async_ch_gnt", 32'(ch_gnt), 0);
        check("async_ch_valid", 32'(ch_valid), 0);
        hold_ack = 0;
        repeat (2) @(negedge clk_sys);
        reset_n = 1;
        repeat (3) @(negedge clk_sys);
        check("idle_after_reset", 32'(mem_req), 0);
        base = gnt_seen;
        push_rd(0);
        ch_req = 4'b1111;
        wait_gnt(base + 1, "gnt_after_reset");
        ch_req = '0;
        drain("drain_reset");

        check("left_mem", 32'(exp_mem.size()), 0);
        check("left_gnt", 32'(exp_gnt.size()), 0);
        check("left_val", 32'(exp_val.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sample_fetch_arbiter.md
Name: sample_fetch_arbiter

Overview:
- Sits between the SDRAM sample-player controller and its users.
- Shares the single-word SDRAM request port between two requester types:
  - the ROM/sample download stream (ioctl byte writes);
  - NUM_CH sample-playback channels, which read 16-bit sample words.
- Download writes have absolute priority. Channels are served round-robin.
- Download bytes are packed into 16-bit words before being written.

Parameters:
- NUM_CH, 4: number of playback read channels (2..8).
- ADDR_W, 24: SDRAM word-address width.
- DL_INDEX, 2: ioctl_index value that selects sample downloads.

Ports:
- clk_sys, input, 1: system clock (50 MHz domain).
- reset_n, input, 1: asynchronous, active-low reset.
- dl_download, input, 1: ioctl_download level.
- dl_index, input, 8: ioctl_index.
- dl_wr, input, 1: byte-write strobe, one cycle.
- dl_addr, input, 25: byte address.
- dl_data, input, 8: byte data.
- dl_overrun, output, 1: sticky flag; a word was lost during download.
- ch_req, input, NUM_CH: per-channel read request level, held until ch_gnt.
- ch_addr, input, NUM_CH*ADDR_W: per-channel word address; channel i uses slice [i*ADDR_W +: ADDR_W].
- ch_gnt, output, NUM_CH: one-hot, one-cycle pulse when the channel's request is issued.
- ch_valid, output, NUM_CH: one-hot, one-cycle pulse when rd_data is valid.
- rd_data, output, 16: read data, registered.
- mem_req, output, 1: request to the SDRAM controller; held until mem_ack.
- mem_we, output, 1: 1 = write, 0 = read.
- mem_addr, output, ADDR_W: word address.
- mem_din, output, 16: write data.
- mem_ack, input, 1: one-cycle completion pulse.
- mem_dout, input, 16: read data, valid with mem_ack.

Behaviour:
- Reset values: all outputs 0. Round-robin pointer = 0. Pack buffer empty. FSM in IDLE.
- Download packing (active when dl_download && dl_index == DL_INDEX):
  - Even byte address: latch the low byte; byte_pending = 1.
  - Odd byte address: form {dl_data, low}; set wr_pending = 1 with word address dl_addr[24:1].
  - Odd byte with no byte_pending: high byte is used, low byte = 0x00.
  - Odd byte while wr_pending is still 1: the new word is dropped; dl_overrun is set (sticky).
  - dl_overrun clears only on reset or on the rising edge of dl_download.
  - Falling edge of dl_download with byte_pending: the word is flushed as {8'h00, low}.
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE with wr_pending: go to ISSUE with mem_we = 1, mem_din = packed word, mem_addr = pending word address.
  - IDLE with no wr_pending and not downloading: pick the first asserted ch_req at or after the pointer, wrapping modulo NUM_CH. Latch its ch_addr and pulse ch_gnt for that channel. Go to ISSUE with mem_we = 0.
  - ISSUE: assert mem_req. The request is visible in the cycle after the decision in IDLE. Go to WAIT.
  - WAIT: hold mem_req, mem_we, mem_addr and mem_din stable until mem_ack.
    - On a write ack: clear wr_pending.
    - On a read ack: register mem_dout to rd_data and pulse ch_valid of the granted channel one cycle later. Pointer = granted channel + 1, wrapping NUM_CH-1 to 0.
    - mem_req deasserts in the cycle after mem_ack. Go to IDLE.
- mem_ack outside WAIT is ignored.
- While a download is active, channel requests are never granted; their ch_req levels are simply left pending.
- Simultaneous events:
  - A new dl_wr in the same cycle that wr_pending clears is accepted; no overrun.
  - When the pointer's own channel is requesting, it wins.
- Latency: minimum request-to-ch_valid is 3 cycles plus the SDRAM latency.
- Throughput: one access per (ack + 2) cycles.
- Asynchronous reset mid-access: mem_req drops immediately. The SDRAM controller tolerates an abandoned request. No ch_valid is generated for the lost access.

Decomposition:
- Shared package sfa_pkg holds:
  - FSM state enum (IDLE, ISSUE, WAIT);
  - the DL_INDEX default;
  - a function for the round-robin next-index.
- One sub-module, sfa_rr_pick: combinational round-robin priority picker. Inputs: req vector and pointer. Outputs: one-hot grant and index.

Test Plan:
- Download bytes 0x11, 0x22 at addresses 0, 1 → one write: mem_addr = 0, mem_din = 0x2211, mem_we = 1; dl_overrun stays 0.
- Download 3 bytes (0xAA, 0xBB, 0xCC), then drop dl_download → writes 0xBBAA at word 0 and 0x00CC at word 1.
- Hold mem_ack off and issue two odd-byte words back-to-back → second word dropped, dl_overrun = 1; next dl_download rise clears it.
- ch_req = 4'b1111 with ack latency 2 → grant order 0, 1, 2, 3, 0. Each ch_valid carries mem_dout (e.g. 0x1234 for ch0) exactly one cycle after its ack.
- ch_req[2] held while downloading with wr_pending → no ch_gnt until dl_download falls and the flush write is acked; then ch_gnt[2] pulses.
- Assert reset_n low during WAIT → mem_req, ch_gnt and ch_valid go to 0 asynchronously; after release the FSM is in IDLE and the pointer is 0.
